// File: rtl/class_decision_voter_if.sv
// Classifier-to-voter bundle: stage/class index in from the classifier,
// debounced decision and status out to the LED logic.
interface class_decision_voter_if #(
    parameter int CLASS_W = 2,
    parameter int STAGE_W = 6
);
    logic [STAGE_W-1:0] stage;
    logic [CLASS_W-1:0] result_in;
    logic [CLASS_W-1:0] decision;
    logic               decision_valid;
    logic               decision_chg;
    logic [4:0]         vote_count;
    logic [4:0]         hist_fill;
    logic               stale;
    logic               drop;

    modport master (
        output stage, result_in,
        input  decision, decision_valid, decision_chg, vote_count, hist_fill, stale, drop
    );

    modport slave (
        input  stage, result_in,
        output decision, decision_valid, decision_chg, vote_count, hist_fill, stale, drop
    );
endinterface

// File: rtl/class_decision_voter.sv
// Sliding-window majority voter over classifier results: one sample per pass,
// debounced decision with stale detection when passes stop arriving.
module class_decision_voter #(
    parameter int          CLASS_W       = 2,
    parameter int          STAGE_W       = 6,
    parameter int          CAPTURE_STAGE = 38,
    parameter int          HIST_DEPTH    = 8,
    parameter int          VOTE_THRESH   = 5,
    parameter int unsigned TIMEOUT_CYC   = 25_000_000
) (
    input logic                   clk,
    input logic                   reset,
    class_decision_voter_if.slave bus
);
    localparam int unsigned NCLASS = 2 ** CLASS_W;
    localparam int          PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int          TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [STAGE_W-1:0] CAP_VAL  = STAGE_W'(CAPTURE_STAGE);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(HIST_DEPTH - 1);
    localparam logic [4:0]         DEPTH_V  = 5'(HIST_DEPTH);
    localparam logic [4:0]         THRESH_V = 5'(VOTE_THRESH);
    localparam logic [TMR_W-1:0]   TMR_SAT  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]   TMR_HIT  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_EVAL} state_t;

    state_t             state, state_nxt;
    logic [STAGE_W-1:0] stage_q;
    logic               cap;
    logic               pending;
    logic [CLASS_W-1:0] pend_sample;
    logic [CLASS_W-1:0] cur_sample;
    logic [CLASS_W-1:0] window [HIST_DEPTH];
    logic [4:0]         cnt    [NCLASS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [TMR_W-1:0]   timer;
    logic               timeout_hit;
    logic               full;
    logic [CLASS_W-1:0] best_idx;
    logic [4:0]         best_cnt;

    always_comb begin
        cap         = (bus.stage == CAP_VAL) && (stage_q != CAP_VAL);
        timeout_hit = (TIMEOUT_CYC != 0) && (timer == TMR_HIT) && !cap;
        full        = (bus.hist_fill == DEPTH_V);
    end

    // Strict '>' keeps the lowest class index on ties.
    always_comb begin
        best_idx = '0;
        best_cnt = cnt[0];
        for (int unsigned i = 1; i < NCLASS; i++) begin
            if (cnt[CLASS_W'(i)] > best_cnt) begin
                best_idx = CLASS_W'(i);
                best_cnt = cnt[CLASS_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cap || pending) state_nxt = S_COUNT;
            S_COUNT: state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q            <= '0;
            pending            <= 1'b0;
            pend_sample        <= '0;
            cur_sample         <= '0;
            wr_ptr             <= '0;
            timer              <= '0;
            bus.decision       <= '0;
            bus.decision_valid <= 1'b0;
            bus.decision_chg   <= 1'b0;
            bus.vote_count     <= '0;
            bus.hist_fill      <= '0;
            bus.stale          <= 1'b0;
            bus.drop           <= 1'b0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) window[PTR_W'(i)] <= '0;
            for (int unsigned i = 0; i < NCLASS; i++)     cnt[CLASS_W'(i)]  <= '0;
        end else begin
            stage_q          <= bus.stage;
            bus.decision_chg <= 1'b0;

            if (cap) timer <= '0;
            else if (timer != TMR_SAT) timer <= timer + 1'b1;

            // A cap arriving while a sample already waits is lost; in IDLE the
            // waiting sample is consumed below, so pending still clears.
            if (cap) begin
                bus.stale <= 1'b0;
                if (pending) begin
                    bus.drop <= 1'b1;
                end else if (state == S_IDLE) begin
                    cur_sample <= bus.result_in;
                end else begin
                    pending     <= 1'b1;
                    pend_sample <= bus.result_in;
                end
            end
            if (state == S_IDLE && pending) begin
                pending    <= 1'b0;
                cur_sample <= pend_sample;
            end

            if (timeout_hit) begin
                bus.stale          <= 1'b1;
                bus.decision_valid <= 1'b0;
                bus.hist_fill      <= '0;
                wr_ptr             <= '0;
                for (int unsigned i = 0; i < NCLASS; i++) cnt[CLASS_W'(i)] <= '0;
            end else if (state == S_COUNT) begin
                window[wr_ptr] <= cur_sample;
                wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (!full) begin
                    cnt[cur_sample] <= cnt[cur_sample] + 5'd1;
                    bus.hist_fill   <= bus.hist_fill + 5'd1;
                end else if (window[wr_ptr] != cur_sample) begin
                    cnt[cur_sample]     <= cnt[cur_sample] + 5'd1;
                    cnt[window[wr_ptr]] <= cnt[window[wr_ptr]] - 5'd1;
                end
            end else if (state == S_EVAL) begin
                if (best_cnt >= THRESH_V && (best_idx != bus.decision || !bus.decision_valid)) begin
                    bus.decision       <= best_idx;
                    bus.decision_valid <= 1'b1;
                    bus.decision_chg   <= 1'b1;
                    bus.vote_count     <= best_cnt;
                end else begin
                    bus.vote_count <= cnt[bus.decision];
                end
            end
        end
    end
endmodule

// File: tb/tb_class_decision_voter.sv
// Directed bench for class_decision_voter: default-parameter instance A and a
// short-timeout, threshold-4 instance B.
module tb_class_decision_voter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;
    int   chg_a = 0;
    int   chg_b = 0;
    int   base;

    always #20 clk = ~clk;

    class_decision_voter_if #(.CLASS_W(2), .STAGE_W(6)) bus_a ();
    class_decision_voter_if #(.CLASS_W(2), .STAGE_W(6)) bus_b ();

    class_decision_voter #(
        .CLASS_W(2), .STAGE_W(6), .CAPTURE_STAGE(38), .HIST_DEPTH(8),
        .VOTE_THRESH(5), .TIMEOUT_CYC(25_000_000)
    ) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

    class_decision_voter #(
        .CLASS_W(2), .STAGE_W(6), .CAPTURE_STAGE(38), .HIST_DEPTH(8),
        .VOTE_THRESH(4), .TIMEOUT_CYC(100)
    ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    always @(posedge clk) if (bus_a.decision_chg === 1'b1) chg_a++;
    always @(posedge clk) if (bus_b.decision_chg === 1'b1) chg_b++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cap_a(input logic [1:0] cls, input int gap);
        bus_a.stage     = 6'd38;
        bus_a.result_in = cls;
        @(negedge clk);
        bus_a.stage = 6'd0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic cap_b(input logic [1:0] cls, input int gap);
        bus_b.stage     = 6'd38;
        bus_b.result_in = cls;
        @(negedge clk);
        bus_b.stage = 6'd0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.stage = '0; bus_a.result_in = '0;
        bus_b.stage = '0; bus_b.result_in = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        check("rst_a_decision", bus_a.decision, 0);
        check("rst_a_valid",    bus_a.decision_valid, 0);
        check("rst_a_chg",      bus_a.decision_chg, 0);
        check("rst_a_votes",    bus_a.vote_count, 0);
        check("rst_a_fill",     bus_a.hist_fill, 0);
        check("rst_a_stale",    bus_a.stale, 0);
        check("rst_a_drop",     bus_a.drop, 0);
        check("rst_b_valid",    bus_b.decision_valid, 0);

        // Five class-2 captures; decision appears only with the fifth.
        for (int k = 1; k <= 4; k++) begin
            cap_a(2'd2, 6);
            check("t1_pre_decision", bus_a.decision, 0);
            check("t1_pre_valid",    bus_a.decision_valid, 0);
        end
        check("t1_fill4",  bus_a.hist_fill, 4);
        check("t1_votes4", bus_a.vote_count, 0);
        bus_a.stage = 6'd38; bus_a.result_in = 2'd2;
        @(negedge clk);
        bus_a.stage = 6'd0;
        check("t1_lat1_valid", bus_a.decision_valid, 0);
        @(negedge clk);
        check("t1_lat2_valid", bus_a.decision_valid, 0);
        check("t1_lat2_chg",   bus_a.decision_chg, 0);
        @(negedge clk);
        check("t1_lat3_decision", bus_a.decision, 2);
        check("t1_lat3_valid",    bus_a.decision_valid, 1);
        check("t1_lat3_votes",    bus_a.vote_count, 5);
        check("t1_lat3_chg",      bus_a.decision_chg, 1);
        @(negedge clk);
        check("t1_lat4_chg",   bus_a.decision_chg, 0);
        check("t1_chg_pulses", chg_a, 1);

        // Stage held at the capture value: one sample only.
        bus_a.stage = 6'd38; bus_a.result_in = 2'd2;
        repeat (100) @(negedge clk);
        bus_a.stage = 6'd0;
        repeat (6) @(negedge clk);
        check("t2_fill",  bus_a.hist_fill, 6);
        check("t2_votes", bus_a.vote_count, 6);
        check("t2_chg",   chg_a, 1);

        // Window wrap: 8x class 1 then 8x class 3.
        rst_a = 1'b1; repeat (2) @(negedge clk); rst_a = 1'b0;
        base = chg_a;
        for (int k = 0; k < 8; k++) cap_a(2'd1, 6);
        check("t3_dec1",   bus_a.decision, 1);
        check("t3_votes8", bus_a.vote_count, 8);
        check("t3_fill8",  bus_a.hist_fill, 8);
        for (int k = 0; k < 4; k++) cap_a(2'd3, 6);
        check("t3_hold_dec",   bus_a.decision, 1);
        check("t3_hold_votes", bus_a.vote_count, 4);
        cap_a(2'd3, 6);
        check("t3_flip_dec",   bus_a.decision, 3);
        check("t3_flip_votes", bus_a.vote_count, 5);
        for (int k = 0; k < 3; k++) cap_a(2'd3, 6);
        check("t3_end_votes", bus_a.vote_count, 8);
        check("t3_end_fill",  bus_a.hist_fill, 8);
        check("t3_chg",       chg_a - base, 2);

        // Rapid captures: two back-to-back both counted, then a train that overruns pending.
        rst_a = 1'b1; repeat (2) @(negedge clk); rst_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_a.stage = 6'd38; bus_a.result_in = 2'd1;
            @(negedge clk);
            bus_a.stage = 6'd0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("t5_pair_fill", bus_a.hist_fill, 2);
        check("t5_pair_drop", bus_a.drop, 0);
        for (int k = 0; k < 4; k++) begin
            bus_a.stage = 6'd38; bus_a.result_in = (k == 3) ? 2'd3 : 2'd1;
            @(negedge clk);
            bus_a.stage = 6'd0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("t5_train_fill",  bus_a.hist_fill, 5);
        check("t5_train_drop",  bus_a.drop, 1);
        check("t5_train_dec",   bus_a.decision, 1);
        check("t5_train_votes", bus_a.vote_count, 5);

        // Tie between classes 1 and 2 at threshold 4.
        rst_b = 1'b1; repeat (2) @(negedge clk); rst_b = 1'b0;
        base = chg_b;
        for (int k = 0; k < 8; k++) cap_b((k % 2 == 0) ? 2'd1 : 2'd2, 8);
        check("t4_dec",   bus_b.decision, 1);
        check("t4_valid", bus_b.decision_valid, 1);
        check("t4_votes", bus_b.vote_count, 4);
        check("t4_fill",  bus_b.hist_fill, 8);
        check("t4_chg",   chg_b - base, 1);
        cap_b(2'd1, 8);
        cap_b(2'd2, 8);
        check("t4_later_dec", bus_b.decision, 1);
        check("t4_later_chg", chg_b - base, 1);

        // Timeout after 100 idle cycles.
        repeat (85) @(negedge clk);
        check("t6_pre_stale", bus_b.stale, 0);
        check("t6_pre_valid", bus_b.decision_valid, 1);
        repeat (10) @(negedge clk);
        check("t6_stale",     bus_b.stale, 1);
        check("t6_valid",     bus_b.decision_valid, 0);
        check("t6_fill",      bus_b.hist_fill, 0);
        check("t6_dec_held",  bus_b.decision, 1);
        base = chg_b;
        cap_b(2'd1, 8);
        check("t6_recap_stale", bus_b.stale, 0);
        check("t6_recap_fill",  bus_b.hist_fill, 1);
        check("t6_recap_valid", bus_b.decision_valid, 0);
        for (int k = 0; k < 3; k++) cap_b(2'd1, 8);
        check("t6_reset_dec",   bus_b.decision, 1);
        check("t6_reset_valid", bus_b.decision_valid, 1);
        check("t6_reset_votes", bus_b.vote_count, 4);
        check("t6_reset_chg",   chg_b - base, 1);

        // Reset asserted so that it is sampled on the EVAL edge.
        bus_b.stage = 6'd38; bus_b.result_in = 2'd1;
        @(negedge clk);
        bus_b.stage = 6'd0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("t6_eval_rst_dec",   bus_b.decision, 0);
        check("t6_eval_rst_valid", bus_b.decision_valid, 0);
        check("t6_eval_rst_chg",   bus_b.decision_chg, 0);
        check("t6_eval_rst_votes", bus_b.vote_count, 0);
        check("t6_eval_rst_fill",  bus_b.hist_fill, 0);
        check("t6_eval_rst_stale", bus_b.stale, 0);
        check("t6_eval_rst_drop",  bus_b.drop, 0);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
